// File: rtl/conv_sched_pkg.sv
// Shared layer codes, state codes, FSM encoding and per-layer geometry lookup
// for the convolution layer scheduler.
package conv_sched_pkg;

  localparam logic [1:0] LAYER_NONE  = 2'd0;
  localparam logic [1:0] LAYER_CONV1 = 2'd1;
  localparam logic [1:0] LAYER_CONV2 = 2'd2;
  localparam logic [1:0] LAYER_CONV3 = 2'd3;

  localparam logic [3:0] ST_IDLE  = 4'b0000;
  localparam logic [3:0] ST_CONV1 = 4'b0010;
  localparam logic [3:0] ST_CONV2 = 4'b0100;
  localparam logic [3:0] ST_CONV3 = 4'b0110;

  localparam int unsigned C1_HW = 32;
  localparam int unsigned C2_HW = 16;
  localparam int unsigned C3_HW = 8;
  localparam int unsigned C1_CI = 1;
  localparam int unsigned C1_CO = 16;
  localparam int unsigned C2_CI = 16;
  localparam int unsigned C2_CO = 32;
  localparam int unsigned C3_CI = 32;
  localparam int unsigned C3_CO = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DONE
  } fsm_t;

  // Limits are stored as (N-1) so they fit the index widths directly.
  typedef struct packed {
    logic [4:0] hw_m1;
    logic [5:0] ci_m1;
    logic [5:0] co_m1;
  } dims_t;

  function automatic dims_t layer_dims(input logic [1:0] l);
    dims_t d;
    case (l)
      LAYER_CONV2: begin
        d.hw_m1 = 5'(C2_HW - 1);
        d.ci_m1 = 6'(C2_CI - 1);
        d.co_m1 = 6'(C2_CO - 1);
      end
      LAYER_CONV3: begin
        d.hw_m1 = 5'(C3_HW - 1);
        d.ci_m1 = 6'(C3_CI - 1);
        d.co_m1 = 6'(C3_CO - 1);
      end
      default: begin
        d.hw_m1 = 5'(C1_HW - 1);
        d.ci_m1 = 6'(C1_CI - 1);
        d.co_m1 = 6'(C1_CO - 1);
      end
    endcase
    return d;
  endfunction

  function automatic logic [3:0] layer_code(input logic [1:0] l);
    logic [3:0] s;
    case (l)
      LAYER_CONV1: s = ST_CONV1;
      LAYER_CONV2: s = ST_CONV2;
      LAYER_CONV3: s = ST_CONV3;
      default:     s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/conv_sched_cnt.sv
// Nested column / row / input-channel / output-channel counter.
// Column is innermost; the output channel holds at its limit once the
// final pixel of the final (o,c) pair has been consumed.
module conv_sched_cnt
  import conv_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  input  logic [4:0] hw_m1,
  input  logic [5:0] ci_m1,
  input  logic [5:0] co_m1,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [5:0] c,
  output logic [5:0] o,
  output logic       pix_last,
  output logic       c_last,
  output logic       o_last
);

  assign pix_last = (x == hw_m1) && (y == hw_m1);
  assign c_last   = (c == ci_m1);
  assign o_last   = (o == co_m1);

  // Step the nest by one pixel on every accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x <= '0;
      y <= '0;
      c <= '0;
      o <= '0;
    end else if (advance) begin
      if (x == hw_m1) begin
        x <= '0;
        if (y == hw_m1) begin
          y <= '0;
          if (!c_last) begin
            c <= c + 6'd1;
          end else if (!o_last) begin
            c <= '0;
            o <= o + 6'd1;
          end
        end else begin
          y <= y + 5'd1;
        end
      end else begin
        x <= x + 5'd1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer scheduler: walks output channel, input channel, row and
// column for one layer, addressing the weight/bias ROMs and emitting one
// handshaked pixel beat per cycle to the MAC datapath.
module conv_layer_sched
  import conv_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] layer,
  input  logic       abort,
  input  logic       out_ready,
  output logic [3:0] state,
  output logic [5:0] read_o,
  output logic [5:0] read_c,
  output logic       wt_en,
  output logic       out_valid,
  output logic [4:0] pix_x,
  output logic [4:0] pix_y,
  output logic       first_c,
  output logic       last_c,
  output logic       busy,
  output logic       done
);

  fsm_t       fsm_q;
  logic [1:0] layer_q;
  dims_t      dims;
  logic       launch;
  logic       xfer;
  logic       cnt_clear;
  logic       pix_last;
  logic       c_last;
  logic       o_last;

  assign dims      = layer_dims(layer_q);
  assign launch    = (fsm_q == S_IDLE) && start && (layer != LAYER_NONE);
  // Abort wins over a beat that would otherwise transfer this edge.
  assign xfer      = out_valid && out_ready && !abort;
  assign cnt_clear = abort || launch;

  conv_sched_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (xfer),
    .hw_m1    (dims.hw_m1),
    .ci_m1    (dims.ci_m1),
    .co_m1    (dims.co_m1),
    .x        (pix_x),
    .y        (pix_y),
    .c        (read_c),
    .o        (read_o),
    .pix_last (pix_last),
    .c_last   (c_last),
    .o_last   (o_last)
  );

  // Accumulator control follows the input channel of the beat on the bus.
  always_comb begin
    first_c = out_valid && (read_c == '0);
    last_c  = out_valid && c_last;
  end

  // Layer sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      fsm_q     <= S_IDLE;
      layer_q   <= (!rst_n) ? LAYER_NONE : layer_q;
      state     <= ST_IDLE;
      wt_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          done <= 1'b0;
          if (launch) begin
            fsm_q     <= S_FETCH;
            layer_q   <= layer;
            state     <= layer_code(layer);
            wt_en     <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          fsm_q     <= S_RUN;
          out_valid <= 1'b1;
        end
        S_RUN: begin
          if (xfer && pix_last) begin
            out_valid <= 1'b0;
            if (c_last && o_last) begin
              fsm_q <= S_DONE;
              wt_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              fsm_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          fsm_q <= S_IDLE;
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed testbench for conv_layer_sched with a small reference walker.
module tb_conv_layer_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] layer;
  logic       abort;
  logic       out_ready;
  logic [3:0] state;
  logic [5:0] read_o;
  logic [5:0] read_c;
  logic       wt_en;
  logic       out_valid;
  logic [4:0] pix_x;
  logic [4:0] pix_y;
  logic       first_c;
  logic       last_c;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  conv_layer_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer     (layer),
    .abort     (abort),
    .out_ready (out_ready),
    .state     (state),
    .read_o    (read_o),
    .read_c    (read_c),
    .wt_en     (wt_en),
    .out_valid (out_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .first_c   (first_c),
    .last_c    (last_c),
    .busy      (busy),
    .done      (done)
  );

  int compares = 0;
  int fails    = 0;

  // Reference walker
  int m_hw, m_ci, m_co, m_code;
  int m_x, m_y, m_c, m_o;
  int cyc, beats, fetches, done_seen, beat_err;
  bit pend_valid;

  task automatic chk(input string tag, input int obs, input int expv);
    compares++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_adv();
    beats++;
    if (m_x == m_hw - 1) begin
      m_x = 0;
      if (m_y == m_hw - 1) begin
        m_y = 0;
        if (m_c < m_ci - 1) m_c++;
        else if (m_o < m_co - 1) begin
          m_c = 0;
          m_o++;
        end
      end else m_y++;
    end else m_x++;
  endtask

  // One clock: retire the pending beat into the model if it will transfer,
  // then sample outputs on the falling edge and compare against the model.
  task automatic cycle();
    if (pend_valid && out_ready && !abort && rst_n) model_adv();
    @(negedge clk);
    cyc++;
    pend_valid = out_valid;
    if (done) done_seen++;
    if (out_valid) begin
      if (pix_x !== 5'(m_x) || pix_y !== 5'(m_y) || read_c !== 6'(m_c) ||
          read_o !== 6'(m_o) || first_c !== (m_c == 0) ||
          last_c !== (m_c == m_ci - 1) || wt_en !== 1'b1 ||
          state !== 4'(m_code) || busy !== 1'b1)
        beat_err++;
    end else begin
      if (first_c !== 1'b0 || last_c !== 1'b0) beat_err++;
      if (busy && wt_en) begin
        fetches++;
        if (read_c !== 6'(m_c) || read_o !== 6'(m_o)) beat_err++;
      end
    end
  endtask

  task automatic start_layer(input logic [1:0] l, input int hw, input int ci,
                             input int co, input int code);
    m_hw = hw; m_ci = ci; m_co = co; m_code = code;
    m_x = 0; m_y = 0; m_c = 0; m_o = 0;
    beats = 0; fetches = 0; done_seen = 0; pend_valid = 1'b0;
    layer = l;
    start = 1'b1;
    cyc = 0;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; layer = 2'd0; abort = 1'b0; out_ready = 1'b1;
    beat_err = 0; pend_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_wt_en", wt_en, 0);
    chk("rst_idx", {read_o, read_c, pix_x, pix_y}, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Invalid start: layer 0 is ignored
    layer = 2'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("inv_busy", busy, 0);
    cycle();
    chk("inv_valid_wt", {out_valid, wt_en}, 0);

    // CONV1 full run, start re-asserted mid-run must be ignored
    start_layer(2'd1, 32, 1, 16, 4'b0010);
    chk("c1_fetch_wt", wt_en, 1);
    chk("c1_fetch_valid", out_valid, 0);
    chk("c1_fetch_state", state, 4'b0010);
    chk("c1_fetch_busy", busy, 1);
    cycle();
    chk("c1_first_beat", {out_valid, read_o, read_c, pix_x, pix_y, first_c, last_c},
        {1'b1, 6'd0, 6'd0, 5'd0, 5'd0, 1'b1, 1'b1});
    while (!done && cyc < 20000) begin
      if (cyc == 100) begin
        start = 1'b1; layer = 2'd2;
      end else start = 1'b0;
      cycle();
    end
    start = 1'b0;
    chk("c1_done_cycle", cyc, 16401);
    chk("c1_beats", beats, 16384);
    chk("c1_fetches", fetches, 16);
    chk("c1_final_o", read_o, 15);
    chk("c1_beat_err", beat_err, 0);
    cycle();
    chk("c1_done_pulse", done_seen, 1);
    chk("c1_idle", {busy, done, state, out_valid}, 0);

    // CONV2 partial run, abort once output channel 3 is streaming
    start_layer(2'd2, 16, 16, 32, 4'b0100);
    while (!(out_valid && read_o == 6'd3) && cyc < 20000) cycle();
    chk("c2_reach_o3", {out_valid, read_o, read_c}, {1'b1, 6'd3, 6'd0});
    chk("c2_beats", beats, 48 * 256);
    chk("c2_fetches", fetches, 49);
    chk("c2_beat_err", beat_err, 0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("c2_abort_busy", busy, 0);
    chk("c2_abort_state", state, 0);
    chk("c2_abort_valid", {out_valid, wt_en}, 0);
    repeat (3) cycle();
    chk("c2_abort_nodone", done_seen, 0);
    chk("c2_abort_hold", busy, 0);

    // CONV1 restart after abort
    start_layer(2'd1, 32, 1, 16, 4'b0010);
    cycle();
    chk("c1r_first", {out_valid, read_o, read_c, pix_x, pix_y},
        {1'b1, 6'd0, 6'd0, 5'd0, 5'd0});
    repeat (1100) cycle();
    chk("c1r_beat_err", beat_err, 0);
    chk("c1r_o1", read_o, 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("c1r_abort", busy, 0);

    // CONV3 backpressure at (x5,y2)
    start_layer(2'd3, 8, 32, 64, 4'b0110);
    while (!(out_valid && pix_x == 5'd5 && pix_y == 5'd2) && cyc < 200) cycle();
    chk("c3_at_5_2", beats, 21);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("c3_stall_frozen", {out_valid, pix_x, pix_y, read_c},
          {1'b1, 5'd5, 5'd2, 6'd0});
    end
    out_ready = 1'b1;
    cycle();
    chk("c3_resume_x", {pix_x, pix_y}, {5'd6, 5'd2});
    chk("c3_resume_beats", beats, 22);
    while (!(out_valid && read_c == 6'd1 && pix_x == 5'd3) && cyc < 400) cycle();
    chk("c3_c1_reached", {read_o, read_c, pix_y}, {6'd0, 6'd1, 5'd0});
    chk("c3_fetches", fetches, 2);
    chk("c3_beat_err", beat_err, 0);

    // Synchronous reset mid-CONV3
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_outs", {state, read_o, read_c, pix_x, pix_y},
        {4'd0, 6'd0, 6'd0, 5'd0, 5'd0});
    chk("rst_mid_flags", {wt_en, out_valid, first_c, last_c, busy, done}, 0);
    cycle();
    chk("rst_mid_idle", busy, 0);

    // Restart after reset
    start_layer(2'd3, 8, 32, 64, 4'b0110);
    chk("rs_fetch", {busy, wt_en, out_valid, state}, {1'b1, 1'b1, 1'b0, 4'b0110});
    repeat (300) cycle();
    chk("rs_beat_err", beat_err, 0);
    chk("rs_progress", read_c, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
